arith_shift_sequencer: RTL and testbench



---
 rtl/arith_shift_sequencer.sv | 97 +++++++++
 tb/tb_arith_shift_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/arith_shift_sequencer.sv
// arith_shift_sequencer
// Multi-cycle arithmetic right shifter: one sign-preserving 1-bit shift per
// clock, then presents the result on Out with a one-cycle Done pulse.
// Optional build macro: ROUND_EN -- when defined, the final value is rounded
// half up (Acc + last bit shifted out); otherwise it is truncated toward -inf.
module arith_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] In1,
  input  logic [CNT_W-1:0] Shamt,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             w_accept;
  logic             w_step;
  logic             w_fin;
  logic [WIDTH-1:0] w_final;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: leave IDLE on Start, return once the count is exhausted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode from the current state
  always_comb begin
    Busy     = (r_state == S_SHIFT);
    w_accept = (r_state == S_IDLE) && Start;
    w_step   = (r_state == S_SHIFT) && (r_cnt != '0);
    w_fin    = (r_state == S_SHIFT) && (r_cnt == '0);
  end

`ifdef ROUND_EN
  logic r_rb;

  // Round bit: last bit shifted out; cleared on accept so Shamt=0 adds nothing
  always_ff @(posedge Clk) begin
    if (Reset)         r_rb <= 1'b0;
    else if (w_accept) r_rb <= 1'b0;
    else if (w_step)   r_rb <= r_acc[0];
  end

  // After at least one shift the magnitude fits in WIDTH-1 bits, so no wrap
  always_comb w_final = r_acc + {{(WIDTH-1){1'b0}}, r_rb};
`else
  // Plain truncation toward -inf
  always_comb w_final = r_acc;
`endif

  // Datapath: load on accept, shift with sign replication, publish on finish
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_accept) begin
        r_acc <= In1;
        r_cnt <= Shamt;
      end else if (w_step) begin
        r_acc <= {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fin) r_out <= w_final;
    end
  end

  assign Done = r_done;
  assign Out  = r_out;

endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Bench for arith_shift_sequencer: cycle model + directed literal vectors.
module tb_arith_shift_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] In1;
  logic [2:0] Shamt;
  logic       Busy;
  logic       Done;
  logic [7:0] Out;

  arith_shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .In1(In1), .Shamt(Shamt),
    .Busy(Busy), .Done(Done), .Out(Out)
  );

  always #5 Clk = ~Clk;

`ifdef ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  // Result by arithmetic: floor(x/2^s) or floor(x/2^s + 1/2)
  function automatic logic [7:0] ref_fn(input logic [7:0] a, input int s);
    int x;
    int r;
    x = int'($signed(a));
    if (RND) r = (2 * x + (1 << s)) >>> (s + 1);
    else     r = x >>> s;
    return r[7:0];
  endfunction

  // ---------------- cycle model ----------------
  int         cyc = 0;
  bit         chk_en = 0;
  bit         m_act = 0;
  bit         m_done = 0;
  logic [7:0] m_out = 8'h00;
  logic [7:0] m_res = 8'h00;
  int         m_end = 0;

  always @(posedge Clk) begin
    bit was;
    if (Reset) begin
      m_act = 0; m_done = 0; m_out = 8'h00; chk_en = 1;
    end else begin
      was    = m_act;
      m_done = 0;
      if (m_act && cyc == m_end) begin
        m_done = 1; m_out = m_res; m_act = 0;
      end
      if (!was && Start) begin
        m_act = 1; m_end = cyc + int'(Shamt) + 1; m_res = ref_fn(In1, int'(Shamt));
      end
    end
    cyc++;
  end

  int n_chk_m = 0, n_err_m = 0;

  // Compare process: every cycle after the first reset
  always @(negedge Clk) begin
    if (chk_en) begin
      n_chk_m++;
      if (Busy !== m_act || Done !== m_done || Out !== m_out) begin
        n_err_m++;
        $display("FAIL model cyc=%0d: got busy=%b done=%b out=%h, want busy=%b done=%b out=%h",
                 cyc, Busy, Done, Out, m_act, m_done, m_out);
      end
    end
  end

  // ---------------- directed ----------------
  int n_chk_d = 0, n_err_d = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk_d++;
    if (got !== exp) begin
      n_err_d++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  // Caller is at a negedge
  task automatic start_op(input logic [7:0] a, input logic [2:0] s);
    Start = 1'b1; In1 = a; Shamt = s;
  endtask

  task automatic wait_done(input int s, input logic [7:0] exp, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 1) begin Start = 1'b0; In1 = 8'hxx; Shamt = 3'bxxx; end
    end while (!Done && n < 40);
    chk({nm, " done"}, int'(Done), 1);
    chk({nm, " latency"}, n, s + 2);
    chk({nm, " out"}, int'(Out), int'(exp));
  endtask

  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; In1 = 8'h00; Shamt = 3'd0;
    repeat (3) @(negedge Clk);
    chk("reset busy", int'(Busy), 0);
    chk("reset done", int'(Done), 0);
    chk("reset out", int'(Out), 0);
    Reset = 1'b0;
    @(negedge Clk);

    // model pins
    chk("ref 81>>1", int'(ref_fn(8'h81, 1)), RND ? 'hC1 : 'hC0);
    chk("ref 7F>>3", int'(ref_fn(8'h7F, 3)), RND ? 'h10 : 'h0F);

    // zero shift: Busy exactly one cycle
    start_op(8'h9C, 3'd0);
    @(negedge Clk); Start = 1'b0;
    chk("zero busy1", int'(Busy), 1);
    @(negedge Clk);
    chk("zero done", int'(Done), 1);
    chk("zero busy0", int'(Busy), 0);
    chk("zero out", int'(Out), 'h9C);

    // reset mid-shift
    start_op(8'h55, 3'd5);
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    chk("rst pre done", int'(Done), 0);
    @(negedge Clk); Reset = 1'b0;
    chk("rst busy", int'(Busy), 0);
    chk("rst done", int'(Done), 0);
    chk("rst out", int'(Out), 0);
    start_op(8'h55, 3'd5);
    wait_done(5, RND ? 8'h03 : 8'h02, "after rst");

    // maximum negative shift
    @(negedge Clk);
    start_op(8'h80, 3'd7);
    wait_done(7, 8'hFF, "max neg");

    @(negedge Clk);
    start_op(8'h81, 3'd1);
    wait_done(1, RND ? 8'hC1 : 8'hC0, "rnd 81");

    @(negedge Clk);
    start_op(8'h7F, 3'd3);
    wait_done(3, RND ? 8'h10 : 8'h0F, "rnd 7F");

    // ignored Start while busy
    @(negedge Clk);
    start_op(8'h40, 3'd3);
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    chk("ign busy", int'(Busy), 1);
    start_op(8'h11, 3'd0);
    @(negedge Clk); Start = 1'b0;
    n = 3;
    while (!Done && n < 40) begin @(negedge Clk); n++; end
    chk("ign latency", n, 5);
    chk("ign out", int'(Out), 'h08);

    // back-to-back: start in the Done cycle
    start_op(8'hF0, 3'd2);
    wait_done(2, 8'hFC, "b2b");

    // a few more through the model
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a;
      logic [2:0] s;
      a = 8'(8'hA7 + i * 37);
      s = 3'(i + 1);
      start_op(a, s);
      wait_done(int'(s), ref_fn(a, int'(s)), "table");
    end

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk_m + n_chk_d, n_err_m + n_err_d);
    $finish;
  end

endmodule
